// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and newline characters for the UART word transmitter
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 frame serializer, data LSB first, each bit held CLKS_PER_BIT cycles
//   clk, rst : clock, asynchronous active-high reset
//   data     : byte to send, latched when the frame is loaded
//   start    : load request, taken when idle or in the final stop-bit cycle
//   busy     : a frame is in progress
//   stop_end : final cycle of the stop bit; a start here chains the next frame with no gap
//   tx       : registered serial line, idle high
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       busy,
    output logic       stop_end,
    output logic       tx
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick;
    assign tick     = baud == BW'(CLKS_PER_BIT - 1);
    assign busy     = state != IDLE;
    assign stop_end = state == STOP && tick;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else if (start && (state == IDLE || stop_end)) begin
            state   <= START;
            tx      <= 1'b0;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= data;
        end else if (busy) begin
            baud <= tick ? '0 : baud + BW'(1);
            if (tick)
                case (state)
                    START: begin
                        state <= DATA;
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                    DATA: begin
                        state   <= bit_idx == 3'd7 ? STOP : DATA;
                        tx      <= bit_idx == 3'd7 ? 1'b1 : shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                endcase
        end
endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: sends a 32-bit word as four back-to-back 8N1 characters, MSB byte first
//   clk, rst : clock, asynchronous active-high reset
//   word_in  : four characters, word_in[31:24] sent first; latched on acceptance
//   start    : send request, accepted only while ready
//   ready    : idle and able to accept start
//   done     : one-cycle pulse as the last stop bit completes
//   tx       : registered serial line, idle high
//   UART_TX_NEWLINE_EN : when defined, CR then LF follow the four characters
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 27000000,
    parameter int BAUD        = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] word_in,
    input  logic        start,
    output logic        ready,
    output logic        done,
    output logic        tx
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
`ifdef UART_TX_NEWLINE_EN
    localparam int NCHAR = 6;
`else
    localparam int NCHAR = 4;
`endif
    localparam int CW = $clog2(NCHAR);
    logic [31:0]   word;
    logic [31:0]   src;
    logic [CW-1:0] char_idx;
    logic [CW-1:0] nxt;
    logic [7:0]    byte_data;
    logic          busy;
    logic          stop_end;
    logic          last_char;
    logic          accept;
    logic          byte_start;
    assign last_char  = char_idx == CW'(NCHAR - 1);
    assign accept     = ready & start & ~busy;
    assign byte_start = accept | (~ready & stop_end & ~last_char);
    // The byte loaded now is either the first of a fresh word or the one after char_idx.
    assign src        = ready ? word_in : word;
    assign nxt        = ready ? '0 : char_idx + CW'(1);
    always_comb begin
        byte_data = src[{~nxt[1:0], 3'b000} +: 8];
`ifdef UART_TX_NEWLINE_EN
        if (nxt[2]) byte_data = nxt[0] ? CHAR_LF : CHAR_CR;
`endif
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ready    <= 1'b1;
            done     <= 1'b0;
            char_idx <= '0;
            word     <= '0;
        end else begin
            done <= ~ready & stop_end & last_char;
            if (accept) begin
                word     <= word_in;
                char_idx <= '0;
                ready    <= 1'b0;
            end else if (~ready & stop_end) begin
                ready    <= last_char;
                char_idx <= last_char ? '0 : char_idx + CW'(1);
            end
        end
    uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk      (clk),
        .rst      (rst),
        .data     (byte_data),
        .start    (byte_start),
        .busy     (busy),
        .stop_end (stop_end),
        .tx       (tx)
    );
endmodule
